// File: rtl/cpu_loader_pkg.sv
// Frame constants and state encodings shared by the iRAM loader and dumper.
package cpu_loader_pkg;

  localparam logic [23:0] START_WORD     = 24'hFF0000;
  localparam logic [23:0] END_RESET_WORD = 24'hFFFF00;
  localparam logic [23:0] END_KEEP_WORD  = 24'hFFF000;

  // ST_SEND covers the whole byte send/release exchange run by word_serializer.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } dump_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_RELEASE
  } ser_state_e;

  typedef enum logic [1:0] {
    PH_HDR,
    PH_DATA,
    PH_TRL
  } phase_e;

  function automatic logic is_flag_word(input logic [23:0] word);
    return (word == START_WORD) || (word == END_RESET_WORD) || (word == END_KEEP_WORD);
  endfunction

endpackage

// File: rtl/cpu_instruction_dumper_if.sv
// Bus between the instruction dumper (master) and the iRAM read port / uart_tx / CPU (slave).
interface cpu_instruction_dumper_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  HALT_flag;
  logic                  dump_request;
  logic [23:0]           iRAM_data_out;
  logic                  tx_ack;
  logic                  iRAM_read_enable;
  logic [ADDR_WIDTH-1:0] extern_iRAM_addr;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  cpu_paused;
  logic                  dump_busy;
  logic                  dump_done;
  logic                  flag_collision;

  modport master (
    input  HALT_flag, dump_request, iRAM_data_out, tx_ack,
    output iRAM_read_enable, extern_iRAM_addr, tx_data, tx_valid,
    output cpu_paused, dump_busy, dump_done, flag_collision
  );

  modport slave (
    output HALT_flag, dump_request, iRAM_data_out, tx_ack,
    input  iRAM_read_enable, extern_iRAM_addr, tx_data, tx_valid,
    input  cpu_paused, dump_busy, dump_done, flag_collision
  );
endinterface

// File: rtl/word_serializer.sv
// Sends a 24-bit word as three bytes, LSB first, over a four-phase valid/ack handshake.
module word_serializer
  import cpu_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_word,
  input  logic        tx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        word_done
);

  ser_state_e  state_q, state_d;
  logic [23:0] sreg_q, sreg_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SER_IDLE;
      sreg_q     <= '0;
      bidx_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bidx_q     <= bidx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Kept outside the comb blocks so the parent can answer with load in the same cycle.
  assign word_done = (state_q == SER_RELEASE) && !tx_ack && (bidx_q == 2'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_SEND:    if (tx_valid_q && tx_ack) state_d = SER_RELEASE;
      SER_RELEASE: if (!tx_ack) state_d = (bidx_q == 2'd2) ? SER_IDLE : SER_SEND;
      default:     ;
    endcase
    if (load) state_d = SER_SEND;
  end

  always_comb begin
    sreg_d     = sreg_q;
    bidx_d     = bidx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      SER_SEND: begin
        if (tx_valid_q && tx_ack) begin
          tx_valid_d = 1'b0;
        end else if (!tx_valid_q && !tx_ack) begin
          tx_data_d  = sreg_q[7:0];
          tx_valid_d = 1'b1;
        end
      end
      SER_RELEASE: begin
        if (!tx_ack) begin
          sreg_d = sreg_q >> 8;
          bidx_d = bidx_q + 2'd1;
        end
      end
      default: ;
    endcase
    if (load) begin
      sreg_d = load_word;
      bidx_d = 2'd0;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/cpu_instruction_dumper.sv
// Streams iRAM words 0..WORD_COUNT-1 to uart_tx, framed by start/end words, with the CPU paused.
module cpu_instruction_dumper
  import cpu_loader_pkg::*;
#(
  parameter int WORD_COUNT = 256,
  parameter int ADDR_WIDTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  cpu_instruction_dumper_if.master  bus
);

  localparam logic [8:0] WORDS = 9'(WORD_COUNT);

  dump_state_e           state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [8:0]            wcnt_q, wcnt_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  paused_q, paused_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  coll_q, coll_d;

  logic        start;
  logic        ser_load;
  logic [23:0] ser_word;
  logic        word_done;
  logic [8:0]  wcnt_inc;

  assign start    = bus.dump_request && bus.HALT_flag;
  assign wcnt_inc = wcnt_q + 9'd1;

  word_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_word (ser_word),
    .tx_ack    (bus.tx_ack),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_HDR;
      wcnt_q   <= '0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      paused_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      wcnt_q   <= wcnt_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      paused_q <= paused_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      coll_q   <= coll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SEND;
      ST_FETCH:   state_d = ST_LATCH;
      ST_LATCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND: begin
        if (word_done) begin
          case (phase_q)
            PH_HDR:  state_d = ST_FETCH;
            PH_DATA: state_d = (wcnt_inc == WORDS) ? ST_SEND : ST_FETCH;
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_d  = phase_q;
    wcnt_d   = wcnt_q;
    rd_en_d  = rd_en_q;
    addr_d   = addr_q;
    paused_d = paused_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    coll_d   = coll_q;
    ser_load = 1'b0;
    ser_word = START_WORD;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          paused_d = 1'b1;
          busy_d   = 1'b1;
          phase_d  = PH_HDR;
          ser_load = 1'b1;
        end
      end
      ST_FETCH: begin
        addr_d  = wcnt_q[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
      end
      ST_LATCH: rd_en_d = 1'b0;
      ST_CAPTURE: begin
        // Flag-valued data is still sent verbatim; the host sees the sticky flag.
        ser_load = 1'b1;
        ser_word = bus.iRAM_data_out;
        if (is_flag_word(bus.iRAM_data_out)) coll_d = 1'b1;
      end
      ST_SEND: begin
        if (word_done) begin
          case (phase_q)
            PH_HDR: begin
              wcnt_d  = '0;
              phase_d = PH_DATA;
            end
            PH_DATA: begin
              wcnt_d = wcnt_inc;
              if (wcnt_inc == WORDS) begin
                ser_load = 1'b1;
                ser_word = END_KEEP_WORD;
                phase_d  = PH_TRL;
              end
            end
            default: ;
          endcase
        end
      end
      ST_DONE: begin
        done_d   = 1'b1;
        paused_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.iRAM_read_enable = rd_en_q;
  assign bus.extern_iRAM_addr = addr_q;
  assign bus.cpu_paused       = paused_q;
  assign bus.dump_busy        = busy_q;
  assign bus.dump_done        = done_q;
  assign bus.flag_collision   = coll_q;

endmodule

// File: doc/cpu_instruction_dumper.md
Name: cpu_instruction_dumper

Overview:
- Reads the instruction RAM back out over UART so the host can verify or archive a program.
- Sits between the iRAM external read port and uart_tx.
- Framing is the reverse of the load path:
  - start word 24'hFF0000, then WORD_COUNT data words, then end word 24'hFFF000;
  - each word is sent as 3 bytes, least-significant byte first.
- Holds the CPU paused for the whole dump.

Parameters:
- WORD_COUNT, 256, number of iRAM words dumped, starting at address 0 (legal range 1..256).
- ADDR_WIDTH, 8, iRAM address width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- HALT_flag  input  1  CPU halted; a dump may only start while this is high
- dump_request  input  1  level or pulse; sampled in IDLE only
- iRAM_data_out  input  24  iRAM read data, valid one cycle after iRAM_read_enable
- tx_ack  input  1  uart_tx has taken the byte; stays high until tx_valid falls
- iRAM_read_enable  output  1  one-cycle read strobe
- extern_iRAM_addr  output  ADDR_WIDTH  iRAM read address
- tx_data  output  8  byte to transmit
- tx_valid  output  1  byte request to uart_tx
- cpu_paused  output  1  high from dump start until done
- dump_busy  output  1  high in every state except IDLE
- dump_done  output  1  one-cycle pulse after the end word's last byte is released
- flag_collision  output  1  sticky; set when a data word equals FF0000, FFFF00 or FFF000

Behaviour:
- Reset: all outputs 0; state IDLE; word counter 0; byte index 0.
  - Reset mid-dump: next edge returns to IDLE with tx_valid=0 and cpu_paused=0.
  - A partially sent word is abandoned.
  - flag_collision is cleared only by rst.
- Internal registers:
  - 24-bit shift register sreg;
  - 9-bit word counter wcnt, so WORD_COUNT=256 does not wrap;
  - 2-bit byte index bidx.
- States:
  - IDLE: if dump_request & HALT_flag, then cpu_paused<=1, dump_busy<=1, sreg<=24'hFF0000, bidx<=0, go to SEND.
    - dump_request while HALT_flag=0 is ignored, not queued.
  - FETCH: extern_iRAM_addr<=wcnt[ADDR_WIDTH-1:0], iRAM_read_enable<=1, go to LATCH.
  - LATCH: iRAM_read_enable<=0, go to CAPTURE.
  - CAPTURE: sreg<=iRAM_data_out; set flag_collision if the word matches a flag value (it is still sent unchanged); bidx<=0, go to SEND.
  - SEND: tx_data<=sreg[7:0], tx_valid<=1. On tx_ack=1: tx_valid<=0, go to RELEASE.
  - RELEASE: wait for tx_ack=0. Then sreg<=sreg>>8 and bidx<=bidx+1.
    - If bidx<2: go to SEND.
    - Else the word is complete; choose the next step from the phase:
      - after the start word: wcnt<=0, go to FETCH;
      - after a data word: wcnt<=wcnt+1; if wcnt+1==WORD_COUNT, load sreg<=24'hFFF000 and go to SEND; else go to FETCH;
      - after the end word: go to DONE.
    - Phase is a 2-bit register: HDR, DATA, TRL.
  - DONE: dump_done<=1 for one cycle, cpu_paused<=0, dump_busy<=0, go to IDLE.
- Handshake: four-phase.
  - tx_data must be stable whenever tx_valid=1.
  - tx_valid never rises while tx_ack=1.
  - A byte is never re-sent on a held tx_ack.
- HALT_flag is ignored after dump start; the CPU is paused.
- dump_request held high re-triggers a new dump after DONE (one idle cycle between dumps).
- Latency: first byte has tx_valid=1 on the 2nd edge after the request is sampled.
  - Each data word costs 3 cycles of iRAM fetch plus 3 byte handshakes.
- Total bytes per dump = 3*(WORD_COUNT+2).

Decomposition:
- Shared package cpu_loader_pkg holds:
  - frame constants START_WORD=24'hFF0000, END_RESET_WORD=24'hFFFF00, END_KEEP_WORD=24'hFFF000 (also used by the loader);
  - state encoding;
  - phase encoding.
- One natural sub-module, word_serializer: 24-bit load, 3-byte LSB-first four-phase sender with a word_done pulse. The top keeps the fetch/phase FSM.

Test Plan:
- WORD_COUNT=4, iRAM={0x123456,0xABCDEF,0x000001,0x7F7F7F}, tx_ack responder with 2-cycle delay → byte stream 00 00 FF 56 34 12 EF CD AB 01 00 00 7F 7F 7F 00 F0 FF; dump_done pulses once; cpu_paused high throughout.
- dump_request with HALT_flag=0 → no tx_valid for 100 cycles, cpu_paused stays 0; then raise HALT_flag with the request → dump proceeds.
- iRAM[1]=0xFFFF00 → word sent as 00 FF FF, flag_collision=1 and still 1 after dump_done.
- rst asserted while the 2nd byte of word 2 is waiting for tx_ack → next cycle tx_valid=0, cpu_paused=0, dump_busy=0; a new request restarts from the start word.
- WORD_COUNT=256 → 774 bytes sent; addresses 0..255 each read exactly once; no address wrap to 0 after 255.
- Responder holds tx_ack high for 10 cycles → tx_valid stays low until tx_ack falls; no duplicate bytes.
